// File: rtl/dts_pkg.sv
// Shared DTS definitions: FSM state encoding, marker bit order and counter sizing.
// Used by the frame generator and by the receive-side offsetter/reorder blocks.
package dts_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } dts_state_e;

    typedef struct packed {
        logic sync;
        logic index;
        logic ten_sec;
        logic one_sec;
    } dts_marker_t;

    // Width of a counter that runs 0..modulus-1; never narrower than one bit.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/dts_frame_gen_if.sv
// Sample-in / frame-out bundle of the DTS frame generator.
// The master drives samples and timing strobes; the slave returns frames and status.
interface dts_frame_gen_if #(
    parameter int W             = 32,
    parameter int OUTPUT_DWIDTH = 128
);
    logic                     enable;
    logic                     pps;
    logic [W-1:0]             din;
    logic                     din_valid;
    logic [OUTPUT_DWIDTH-1:0] dout;
    logic                     dout_valid;
    logic                     dout_sync;
    logic                     dout_index;
    logic                     dout_one_sec;
    logic                     dout_ten_sec;
    logic                     pps_slip;
    logic [1:0]               state_out;

    modport master (
        output enable, pps, din, din_valid,
        input  dout, dout_valid, dout_sync, dout_index, dout_one_sec, dout_ten_sec,
               pps_slip, state_out
    );

    modport slave (
        input  enable, pps, din, din_valid,
        output dout, dout_valid, dout_sync, dout_index, dout_one_sec, dout_ten_sec,
               pps_slip, state_out
    );
endinterface

// File: rtl/dts_gearbox_n2w.sv
// Narrow-to-wide gather: packs 1<<LANE_BITS words, first word in the LSB lane.
// flush_i drops the partial frame; a write on the same edge restarts at lane 0.
module dts_gearbox_n2w #(
    parameter int LANE_BITS = 2,
    parameter int W         = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        wr_en_i,
    input  logic [W-1:0]                din_i,
    output logic [(W<<LANE_BITS)-1:0]   frame_o,
    output logic [LANE_BITS-1:0]        lane_cnt_o,
    output logic                        done_o
);
    localparam int NLANES = 1 << LANE_BITS;
    localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(NLANES - 1);

    logic [LANE_BITS-1:0]         lane_q, lane_d, wr_lane;
    logic [NLANES-1:0][W-1:0]     gather_q, gather_d;
    logic                         done_q, done_d;

    assign wr_lane = flush_i ? '0 : lane_q;

    for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
        assign gather_d[gi] = (wr_en_i && (wr_lane == LANE_BITS'(gi))) ? din_i :
                              (flush_i ? '0 : gather_q[gi]);
    end

    always_comb begin
        lane_d = lane_q;
        done_d = 1'b0;
        if (flush_i) begin
            lane_d = '0;
        end
        if (wr_en_i) begin
            lane_d = wr_lane + 1'b1;
            done_d = (wr_lane == LAST_LANE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q   <= '0;
            gather_q <= '0;
            done_q   <= 1'b0;
        end else begin
            lane_q   <= lane_d;
            gather_q <= gather_d;
            done_q   <= done_d;
        end
    end

    assign frame_o    = gather_q;
    assign lane_cnt_o = lane_q;
    assign done_o     = done_q;

endmodule

// File: rtl/dts_frame_gen.sv
// DTS transmit framer: gathers narrow samples into frames and stamps sync/index/
// one_sec/ten_sec markers aligned to the 1PPS strobe, flagging misaligned PPS.
module dts_frame_gen
    import dts_pkg::*;
#(
    parameter int MUX_FACTOR_BITS  = 2,
    parameter int OUTPUT_DWIDTH    = 128,
    parameter int FRAMES_PER_INDEX = 16,
    parameter int FRAMES_PER_SEC   = 1250000,
    parameter int SECS_PER_TEN     = 10
) (
    input  logic          clk,
    input  logic          rst,
    dts_frame_gen_if.slave bus
);
    localparam int W   = OUTPUT_DWIDTH >> MUX_FACTOR_BITS;
    localparam int FCW = cnt_width(FRAMES_PER_SEC);
    localparam int SCW = cnt_width(SECS_PER_TEN);
    localparam logic [FCW-1:0]             FRAME_LAST = FCW'(FRAMES_PER_SEC - 1);
    localparam logic [SCW-1:0]             SEC_LAST   = SCW'(SECS_PER_TEN - 1);
    localparam logic [MUX_FACTOR_BITS-1:0] LAST_LANE  = '1;

    dts_state_e                 state_q, state_d;
    logic                       gb_wr, gb_flush, enter_run, realign, complete, pps_expected;
    logic [MUX_FACTOR_BITS-1:0] lane_cnt;
    logic [OUTPUT_DWIDTH-1:0]   gather;
    logic                       gb_done;
    logic [FCW-1:0]             frame_cnt_q;
    logic [SCW-1:0]             sec_cnt_q;
    logic                       sync_pend_q;
    dts_marker_t                mark_d, mark_q, dout_mark_q;
    logic [OUTPUT_DWIDTH-1:0]   dout_q;
    logic                       dout_valid_q;
    logic                       pps_slip_q;

    dts_gearbox_n2w #(
        .LANE_BITS (MUX_FACTOR_BITS),
        .W         (W)
    ) u_gearbox (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (gb_flush),
        .wr_en_i    (gb_wr),
        .din_i      (bus.din),
        .frame_o    (gather),
        .lane_cnt_o (lane_cnt),
        .done_o     (gb_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.enable) state_d = ST_ARMED;
            ST_ARMED: begin
                if (!bus.enable)  state_d = ST_IDLE;
                else if (bus.pps) state_d = ST_RUN;
            end
            ST_RUN:   if (!bus.enable) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Frame counters run one frame ahead of dout, so they already point at the
    // frame being gathered when the next PPS is judged.
    assign pps_expected = bus.din_valid && (lane_cnt == '0) && (frame_cnt_q == '0);

    always_comb begin
        gb_wr     = 1'b0;
        gb_flush  = 1'b1;
        enter_run = 1'b0;
        realign   = 1'b0;
        case (state_q)
            ST_ARMED: begin
                if (bus.enable && bus.pps) begin
                    enter_run = 1'b1;
                    gb_wr     = bus.din_valid;
                end
            end
            ST_RUN: begin
                if (!bus.enable) begin
                    // A word that finishes the frame is still taken on the way out.
                    if (bus.din_valid && (lane_cnt == LAST_LANE)) begin
                        gb_wr    = 1'b1;
                        gb_flush = 1'b0;
                    end
                end else begin
                    gb_flush = 1'b0;
                    gb_wr    = bus.din_valid;
                    if (bus.pps && !pps_expected) begin
                        realign  = 1'b1;
                        gb_flush = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign complete = gb_wr && !gb_flush && (lane_cnt == LAST_LANE);

    always_comb begin
        mark_d.sync    = sync_pend_q;
        mark_d.index   = ((int'(frame_cnt_q) % FRAMES_PER_INDEX) == 0);
        mark_d.one_sec = (frame_cnt_q == '0);
        mark_d.ten_sec = (frame_cnt_q == '0) && (sec_cnt_q == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            sec_cnt_q   <= '0;
            sync_pend_q <= 1'b0;
            mark_q      <= '0;
            pps_slip_q  <= 1'b0;
        end else begin
            if ((state_q == ST_ARMED) || realign) begin
                frame_cnt_q <= '0;
                sec_cnt_q   <= '0;
            end else if (complete) begin
                if (frame_cnt_q == FRAME_LAST) begin
                    frame_cnt_q <= '0;
                    sec_cnt_q   <= (sec_cnt_q == SEC_LAST) ? '0 : sec_cnt_q + 1'b1;
                end else begin
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                end
            end

            if (enter_run || realign) begin
                sync_pend_q <= 1'b1;
            end else if (complete) begin
                sync_pend_q <= 1'b0;
            end

            if (complete) begin
                mark_q <= mark_d;
            end

            if ((state_q == ST_IDLE) && bus.enable) begin
                pps_slip_q <= 1'b0;
            end else if (realign) begin
                pps_slip_q <= 1'b1;
            end
        end
    end

    // Output stage only follows the gearbox; PPS or enable changes never cut a frame short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_mark_q  <= '0;
        end else begin
            dout_valid_q <= gb_done;
            dout_mark_q  <= gb_done ? mark_q : '0;
            if (gb_done) begin
                dout_q <= gather;
            end
        end
    end

    assign bus.dout         = dout_q;
    assign bus.dout_valid   = dout_valid_q;
    assign bus.dout_sync    = dout_mark_q.sync;
    assign bus.dout_index   = dout_mark_q.index;
    assign bus.dout_one_sec = dout_mark_q.one_sec;
    assign bus.dout_ten_sec = dout_mark_q.ten_sec;
    assign bus.pps_slip     = pps_slip_q;
    assign bus.state_out    = state_q;

endmodule

// File: tb/tb_dts_frame_gen.sv
// Directed bench for dts_frame_gen with short index/second/ten-second periods.
// Markers are compared as {sync, index, one_sec, ten_sec}.
module tb_dts_frame_gen;
    localparam int MFB  = 2;
    localparam int OW   = 128;
    localparam int W    = 32;
    localparam int FPI  = 2;
    localparam int FPS  = 4;
    localparam int STEN = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    dts_frame_gen_if #(.W(W), .OUTPUT_DWIDTH(OW)) bus_if();

    dts_frame_gen #(
        .MUX_FACTOR_BITS  (MFB),
        .OUTPUT_DWIDTH    (OW),
        .FRAMES_PER_INDEX (FPI),
        .FRAMES_PER_SEC   (FPS),
        .SECS_PER_TEN     (STEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    logic [3:0] mk;
    assign mk = {bus_if.dout_sync, bus_if.dout_index, bus_if.dout_one_sec, bus_if.dout_ten_sec};

    task automatic step(input logic en, input logic p, input logic dv, input logic [31:0] d);
        bus_if.enable    = en;
        bus_if.pps       = p;
        bus_if.din_valid = dv;
        bus_if.din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.enable = 1'b0; bus_if.pps = 1'b0; bus_if.din_valid = 1'b0; bus_if.din = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_if.dout !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", bus_if.dout); end
        checks++; if (bus_if.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus_if.dout_valid); end
        checks++; if (mk !== 4'b0000) begin errors++; $display("FAIL reset_markers got %b want 0000", mk); end
        checks++; if (bus_if.pps_slip !== 1'b0) begin errors++; $display("FAIL reset_slip got %b want 0", bus_if.pps_slip); end
        checks++; if (bus_if.state_out !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus_if.state_out); end
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b1, 32'hdead_beef);
        checks++; if (bus_if.state_out !== 2'd0) begin errors++; $display("FAIL idle_state got %0d want 0", bus_if.state_out); end
        checks++; if (bus_if.dout_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", bus_if.dout_valid); end
        $display("test_reset done");
    endtask

    task automatic test_first_frame();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (bus_if.state_out !== 2'd1) begin errors++; $display("FAIL armed_state got %0d want 1", bus_if.state_out); end
        step(1'b1, 1'b1, 1'b1, 32'h1);
        checks++; if (bus_if.state_out !== 2'd2) begin errors++; $display("FAIL run_state got %0d want 2", bus_if.state_out); end
        step(1'b1, 1'b0, 1'b1, 32'h2);
        step(1'b1, 1'b0, 1'b1, 32'h3);
        step(1'b1, 1'b0, 1'b1, 32'h4);
        checks++; if (bus_if.dout_valid !== 1'b0) begin errors++; $display("FAIL first_early_valid got %b want 0", bus_if.dout_valid); end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        $display("first frame valid=%b dout=%h markers=%b", bus_if.dout_valid, bus_if.dout, mk);
        checks++; if (bus_if.dout_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", bus_if.dout_valid); end
        checks++; if (bus_if.dout !== 128'h00000004_00000003_00000002_00000001) begin
            errors++; $display("FAIL first_dout got %h want 00000004000000030000000200000001", bus_if.dout); end
        checks++; if (mk !== 4'b1111) begin errors++; $display("FAIL first_markers got %b want 1111", mk); end
        checks++; if (bus_if.pps_slip !== 1'b0) begin errors++; $display("FAIL first_slip got %b want 0", bus_if.pps_slip); end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (bus_if.dout_valid !== 1'b0) begin errors++; $display("FAIL first_pulse_len got %b want 0", bus_if.dout_valid); end
    endtask

    task automatic test_continuous();
        logic         exp_v;
        int           f;
        logic [127:0] exp_d;
        logic [3:0]   exp_m;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k <= 48; k++) begin
            step(1'b1, (k % 16 == 0) && (k < 48), k < 48, 32'(32'h100 + k));
            exp_v = (k >= 4) && (k % 4 == 0);
            checks++; if (bus_if.dout_valid !== exp_v) begin
                errors++; $display("FAIL cont_valid k=%0d got %b want %b", k, bus_if.dout_valid, exp_v); end
            if (exp_v) begin
                f = k / 4 - 1;
                exp_d = {32'(256 + 4*f + 3), 32'(256 + 4*f + 2), 32'(256 + 4*f + 1), 32'(256 + 4*f)};
                exp_m = {f == 0, f % 2 == 0, f % 4 == 0, f == 0};
                $display("cont frame %0d dout=%h markers=%b", f, bus_if.dout, mk);
                checks++; if (bus_if.dout !== exp_d) begin
                    errors++; $display("FAIL cont_dout f=%0d got %h want %h", f, bus_if.dout, exp_d); end
                checks++; if (mk !== exp_m) begin
                    errors++; $display("FAIL cont_markers f=%0d got %b want %b", f, mk, exp_m); end
            end
        end
        checks++; if (bus_if.pps_slip !== 1'b0) begin errors++; $display("FAIL cont_slip got %b want 0", bus_if.pps_slip); end
    endtask

    task automatic test_gaps();
        logic         exp_v;
        int           fr;
        logic [127:0] exp_d;
        logic [3:0]   exp_m;
        for (int j = 0; j < 8; j++) begin
            step(1'b1, 1'b0, 1'b1, 32'(32'h200 + j));
            checks++; if (bus_if.dout_valid !== 1'b0) begin
                errors++; $display("FAIL gap_word_valid j=%0d got %b want 0", j, bus_if.dout_valid); end
            for (int g = 0; g < 3; g++) begin
                step(1'b1, 1'b0, 1'b0, 32'h0);
                exp_v = (g == 0) && (j % 4 == 3);
                checks++; if (bus_if.dout_valid !== exp_v) begin
                    errors++; $display("FAIL gap_valid j=%0d g=%0d got %b want %b", j, g, bus_if.dout_valid, exp_v); end
                if (exp_v) begin
                    fr = j / 4;
                    exp_d = {32'(512 + 4*fr + 3), 32'(512 + 4*fr + 2), 32'(512 + 4*fr + 1), 32'(512 + 4*fr)};
                    exp_m = (fr == 0) ? 4'b0111 : 4'b0000;
                    $display("gap frame %0d dout=%h markers=%b", fr, bus_if.dout, mk);
                    checks++; if (bus_if.dout !== exp_d) begin
                        errors++; $display("FAIL gap_dout fr=%0d got %h want %h", fr, bus_if.dout, exp_d); end
                    checks++; if (mk !== exp_m) begin
                        errors++; $display("FAIL gap_markers fr=%0d got %b want %b", fr, mk, exp_m); end
                end
            end
        end
    endtask

    task automatic test_pps_slip();
        logic         exp_v;
        logic [127:0] exp_d;
        logic [3:0]   exp_m;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k <= 14; k++) begin
            step(1'b1, (k == 0) || (k == 6), k < 14, 32'(32'h400 + k));
            exp_v = (k == 4) || (k == 10) || (k == 14);
            checks++; if (bus_if.dout_valid !== exp_v) begin
                errors++; $display("FAIL slip_valid k=%0d got %b want %b", k, bus_if.dout_valid, exp_v); end
            checks++; if (bus_if.pps_slip !== (k >= 6)) begin
                errors++; $display("FAIL slip_flag k=%0d got %b want %b", k, bus_if.pps_slip, k >= 6); end
            if (exp_v) begin
                if (k == 4) begin
                    exp_d = 128'h00000403_00000402_00000401_00000400; exp_m = 4'b1111;
                end else if (k == 10) begin
                    exp_d = 128'h00000409_00000408_00000407_00000406; exp_m = 4'b1111;
                end else begin
                    exp_d = 128'h0000040d_0000040c_0000040b_0000040a; exp_m = 4'b0000;
                end
                $display("slip frame k=%0d dout=%h markers=%b", k, bus_if.dout, mk);
                checks++; if (bus_if.dout !== exp_d) begin
                    errors++; $display("FAIL slip_dout k=%0d got %h want %h", k, bus_if.dout, exp_d); end
                checks++; if (mk !== exp_m) begin
                    errors++; $display("FAIL slip_markers k=%0d got %b want %b", k, mk, exp_m); end
            end
        end
    endtask

    task automatic test_enable_drop();
        int en_t[10]    = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        int pps_t[10]   = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        int din_t[10]   = '{'h500, 'h501, 'h502, 'h503, 'h504, 'h505, 'h510, 'h511, 'h512, 'h513};
        int st_t[10]    = '{2, 2, 0, 0, 1, 1, 2, 2, 2, 2};
        int slip_t[10]  = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            step(en_t[i] != 0, pps_t[i] != 0, 1'b1, 32'(din_t[i]));
            checks++; if (bus_if.dout_valid !== 1'b0) begin
                errors++; $display("FAIL drop_valid i=%0d got %b want 0", i, bus_if.dout_valid); end
            checks++; if (bus_if.state_out !== 2'(st_t[i])) begin
                errors++; $display("FAIL drop_state i=%0d got %0d want %0d", i, bus_if.state_out, st_t[i]); end
            checks++; if (bus_if.pps_slip !== (slip_t[i] != 0)) begin
                errors++; $display("FAIL drop_slip i=%0d got %b want %0d", i, bus_if.pps_slip, slip_t[i]); end
        end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        $display("drop frame dout=%h markers=%b", bus_if.dout, mk);
        checks++; if (bus_if.dout_valid !== 1'b1) begin errors++; $display("FAIL drop_out_valid got %b want 1", bus_if.dout_valid); end
        checks++; if (bus_if.dout !== 128'h00000513_00000512_00000511_00000510) begin
            errors++; $display("FAIL drop_dout got %h want 00000513000005120000051100000510", bus_if.dout); end
        checks++; if (mk !== 4'b1111) begin errors++; $display("FAIL drop_markers got %b want 1111", mk); end
    endtask

    task automatic test_drop_on_complete();
        step(1'b1, 1'b0, 1'b1, 32'h600);
        step(1'b1, 1'b0, 1'b1, 32'h601);
        step(1'b1, 1'b0, 1'b1, 32'h602);
        step(1'b0, 1'b0, 1'b1, 32'h603);
        checks++; if (bus_if.state_out !== 2'd0) begin errors++; $display("FAIL cmpl_state got %0d want 0", bus_if.state_out); end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        $display("complete-on-disable frame dout=%h markers=%b", bus_if.dout, mk);
        checks++; if (bus_if.dout_valid !== 1'b1) begin errors++; $display("FAIL cmpl_valid got %b want 1", bus_if.dout_valid); end
        checks++; if (bus_if.dout !== 128'h00000603_00000602_00000601_00000600) begin
            errors++; $display("FAIL cmpl_dout got %h want 00000603000006020000060100000600", bus_if.dout); end
        checks++; if (mk !== 4'b0000) begin errors++; $display("FAIL cmpl_markers got %b want 0000", mk); end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h700);
        step(1'b1, 1'b1, 1'b1, 32'h701);
        checks++; if (bus_if.pps_slip !== 1'b1) begin errors++; $display("FAIL pre_rst_slip got %b want 1", bus_if.pps_slip); end
        checks++; if (bus_if.state_out !== 2'd2) begin errors++; $display("FAIL pre_rst_state got %0d want 2", bus_if.state_out); end
        #3;
        rst = 1'b1;
        #1;
        $display("async reset applied state=%0d slip=%b", bus_if.state_out, bus_if.pps_slip);
        checks++; if (bus_if.dout !== '0) begin errors++; $display("FAIL arst_dout got %h want 0", bus_if.dout); end
        checks++; if (bus_if.dout_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", bus_if.dout_valid); end
        checks++; if (mk !== 4'b0000) begin errors++; $display("FAIL arst_markers got %b want 0000", mk); end
        checks++; if (bus_if.pps_slip !== 1'b0) begin errors++; $display("FAIL arst_slip got %b want 0", bus_if.pps_slip); end
        checks++; if (bus_if.state_out !== 2'd0) begin errors++; $display("FAIL arst_state got %0d want 0", bus_if.state_out); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_continuous();
        test_gaps();
        test_pps_slip();
        test_enable_drop();
        test_drop_on_complete();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
